pipeline_mul_param: RTL
=======================

// Module: pipeline_mul_param
// PURPOSE
//  Parametrised, fully pipelined WIDTH x WIDTH multiplier. One product per cycle,
//  per-operation signed/unsigned mode, valid/ready flow control on both sides.
//  Partial products are formed in stage 1, then reduced by a registered binary adder tree.
//  Sits between datapath producers and consumers that can backpressure.
// PARAMETERS
//  WIDTH    8                      operand width, >= 2; need not be a power of two
//  LEVELS   $clog2(WIDTH)          adder-tree levels; derived, not overridden
//  LATENCY  1+LEVELS               cycles from input accept to output valid; derived
//                                  (WIDTH=4 -> 3, WIDTH=8 -> 4)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        mul_a/mul_b/in_signed valid this cycle
//  in_ready   out  1        block accepts input this cycle
//  in_signed  in   1        1: two's-complement operands; 0: unsigned
//  mul_a      in   WIDTH    multiplicand
//  mul_b      in   WIDTH    multiplier
//  out_valid  out  1        mul_out holds a valid product
//  out_ready  in   1        consumer accepts mul_out this cycle
//  mul_out    out  2*WIDTH  product, full width, no truncation
// BEHAVIOUR
//  Reset (rst=1 at posedge): all stage data regs, valid bits and mul_out clear to 0;
//  out_valid=0. Reset mid-operation discards every in-flight product, with no partial output.
//  advance = !out_valid | out_ready. in_ready = advance; combinational, no dependence on in_valid.
//  Accept = in_valid & in_ready. When advance=0 the whole pipe holds: all data and valid regs frozen.
//  When advance=1 every stage shifts one step. Stage-1 valid <= accept, so bubbles propagate as valid=0.
//  Throughput 1 product/cycle while out_ready=1. An accept at cycle T gives out_valid at T+LATENCY,
//  provided no stalls occur.
//  Stalls add cycles 1:1. Products are never dropped, duplicated or reordered.
//  Stage 1 (partial products): a_ext = mul_a extended to 2*WIDTH (sign-extended if in_signed,
//  zero-extended otherwise).
//   pp[i] = mul_b[i] ? (a_ext << i) : 0, for i in 0..WIDTH-1.
//   If in_signed, pp[WIDTH-1] is replaced by its two's-complement negation (MSB of b weighs -2^(W-1)).
//  Tree: level k adds adjacent pairs from level k-1. An odd leftover passes through
//  registered, i.e. padded with 0.
//   Every level is registered. All sums are 2*WIDTH bits; carries beyond bit 2*WIDTH-1 are discarded.
//   The result equals the exact product modulo 2^(2*WIDTH), which is always exact for both modes.
//  in_signed is sampled only at accept; it is not carried down the pipe.
//  out_valid & !out_ready: mul_out is stable until the handshake completes.
//  Simultaneous output handshake and new accept in the same cycle is legal and required at full rate.
//  in_valid=0 with advance=1: a bubble enters; mul_out data of bubble cycles is don't-care
//  (out_valid=0).
// TESTING
//  T1 WIDTH=4 unsigned: a=15,b=15 accepted at T0 -> out_valid at T0+3, mul_out=8'd225.
//  T2 WIDTH=8 signed:
//     (-128)*(-128) -> 16'h4000;
//     (-1)*1 -> 16'hFFFF;
//     127*(-128) -> 16'hC080.
//     Unsigned 255*255 -> 16'hFE01.
//  T3 WIDTH=8 back-to-back: 16 accepts on consecutive cycles (a=i, b=i+1, alternating in_signed),
//     out_ready=1 -> 16 consecutive out_valid cycles starting at LATENCY, in order, all correct.
//  T4 Backpressure: fill pipe, hold out_ready=0 for 5 cycles -> in_ready=0, mul_out/out_valid
//     frozen; release -> remaining products appear in order, none lost or duplicated.
//  T5 Reset mid-flight: 3 products in pipe, assert rst one cycle -> next cycle out_valid=0,
//     mul_out=0, in_ready=1; none of the 3 products ever emerge.
//  T6 Random: WIDTH in {2,5,8,16}, 10k ops, random in_valid/out_ready; scoreboard vs reference
//     product mod 2^(2W).

Source files
------------

// File: rtl/pipeline_mul_param_if.sv
// Stream bundle for the pipelined multiplier.
// master drives operands and out_ready; slave is the multiplier.
interface pipeline_mul_param_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] mul_out;

    modport master (
        output in_valid, in_signed, mul_a, mul_b, out_ready,
        input  in_ready, out_valid, mul_out
    );

    modport slave (
        input  in_valid, in_signed, mul_a, mul_b, out_ready,
        output in_ready, out_valid, mul_out
    );
endinterface

// File: rtl/pipeline_mul_param.sv
// Fully pipelined WIDTH x WIDTH multiplier, signed/unsigned per op.
// Partial products in stage 1, then a registered binary adder tree.
module pipeline_mul_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_mul_param_if.slave  bus
);
    localparam int P       = 2 * WIDTH;
    localparam int LEVELS  = $clog2(WIDTH);
    localparam int LATENCY = 1 + LEVELS;

    // Node count of tree level k (level 0 = partial products).
    function automatic int lvl_n(input int k);
        int n;
        n = WIDTH;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // First node index of level k in the flat node array.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) o += lvl_n(i);
        return o;
    endfunction

    localparam int NODES = lvl_off(LEVELS + 1);

    logic [P-1:0]       node_q [NODES];
    logic [P-1:0]       node_d [NODES];
    logic [LATENCY-1:0] vld_q;
    logic [P-1:0]       a_ext;
    logic               advance;
    logic               accept;

    assign advance       = !vld_q[LATENCY-1] | bus.out_ready;
    assign accept        = bus.in_valid & advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.mul_out   = node_q[NODES-1];

    assign a_ext = {{WIDTH{bus.in_signed & bus.mul_a[WIDTH-1]}}, bus.mul_a};

    // The MSB of b carries weight -2^(W-1) in signed mode, so negate its row.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        logic [P-1:0] sh;
        assign sh = a_ext << i;
        if (i == WIDTH - 1) begin : g_msb
            assign node_d[i] = !bus.mul_b[i] ? '0 :
                               bus.in_signed ? -sh : sh;
        end else begin : g_lo
            assign node_d[i] = bus.mul_b[i] ? sh : '0;
        end
    end

    // Each level sums adjacent pairs; an odd leftover passes through.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        for (genvar j = 0; j < lvl_n(k); j++) begin : g_node
            localparam int S = lvl_off(k - 1) + 2 * j;
            localparam int D = lvl_off(k) + j;
            if (2 * j + 1 < lvl_n(k - 1)) begin : g_add
                assign node_d[D] = node_q[S] + node_q[S+1];
            end else begin : g_pass
                assign node_d[D] = node_q[S];
            end
        end
    end

    // Whole pipe shifts together on advance and freezes on backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_q <= '{default: '0};
            vld_q  <= '0;
        end else if (advance) begin
            node_q <= node_d;
            vld_q  <= {vld_q[LATENCY-2:0], accept};
        end
    end
endmodule
